// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: CPU-side read port of the PS/2 receive FIFO.
// Ports: rd_en (pop), rd_data {ext,brk,code}, empty/full/count, error pulses.
interface ps2_rx_fifo_if #(
    parameter int DEPTH = 16
) ();
    logic                         rd_en;
    logic [9:0]                   rd_data;
    logic                         empty;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         parity_err;
    logic                         frame_err;
    logic                         overflow;

    modport master (
        output rd_en,
        input  rd_data, empty, full, count,
        input  parity_err, frame_err, overflow
    );

    modport slave (
        input  rd_en,
        output rd_data, empty, full, count,
        output parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver in the CLK100MHZ domain with a FWFT FIFO.
// Ports: CLK100MHZ, areset_n (async low), PS2_CLK/PS2_DATA raw inputs,
// bus (ps2_rx_fifo_if.slave): rd_en, rd_data, empty, full, count,
// parity_err, frame_err, overflow.
// Option: define PS2_SCANCODE_TAG_EN to fold E0/F0 prefixes into {ext,brk}.
module ps2_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              CLK100MHZ,
    input  logic              areset_n,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    ps2_rx_fifo_if.slave      bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers; reset high so no false edge leaves reset.
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_s;
    logic       dat_s;

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Glitch filter: clk_f follows clk_s only after FILTER_LEN
    // consecutive differing samples.
    logic          clk_f;
    logic [FW-1:0] flt_cnt;
    logic          flt_flip;
    logic          fall;

    assign flt_flip = (clk_s != clk_f) &&
                      (flt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            clk_f   <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= flt_flip & clk_f;
            if (clk_s == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_flip) begin
                clk_f   <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM
    state_t        state;
    state_t        state_nx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_b;
    logic [TW-1:0] tmo_cnt;
    logic          abort;
    logic          frame_ok;
    logic          perr;
    logic          ferr;

    assign abort = (state != IDLE) && !fall &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        frame_ok = 1'b0;
        perr     = 1'b0;
        ferr     = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            ferr     = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE:   if (!dat_s) state_nx = DATA;
                DATA:   if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    // A bad stop bit masks a parity error.
                    if (!dat_s)
                        ferr = 1'b1;
                    else if (^{shreg, par_b})
                        frame_ok = 1'b1;
                    else
                        perr = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_b   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (fall || state == IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (fall && !abort) begin
                unique case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_b <= dat_s;
                    default: ;
                endcase
            end
        end
    end

    // Prefix folding
    logic       push;
    logic [9:0] push_data;

`ifdef PS2_SCANCODE_TAG_EN
    logic ext;
    logic brk;
    logic is_e0;
    logic is_f0;

    assign is_e0     = (shreg == 8'hE0);
    assign is_f0     = (shreg == 8'hF0);
    assign push      = frame_ok && !is_e0 && !is_f0;
    assign push_data = {ext, brk, shreg};

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (perr || ferr) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (frame_ok) begin
            unique case (1'b1)
                is_e0: ext <= 1'b1;
                is_f0: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end
`else
    assign push      = frame_ok;
    assign push_data = {2'b00, shreg};
`endif

    // FWFT FIFO
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr;
    logic          ovf_d;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign pop   = bus.rd_en && !empty;
    // When full, a same-cycle pop frees the slot for the push.
    assign wr    = push && (!full || pop);
    assign ovf_d = push && full && !pop;

    always_ff @(posedge CLK100MHZ) begin
        if (wr)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Registered error pulses
    logic parity_err_q;
    logic frame_err_q;
    logic overflow_q;

    always_ff @(posedge CLK100MHZ or negedge areset_n) begin
        if (!areset_n) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            parity_err_q <= perr;
            frame_err_q  <= ferr;
            overflow_q   <= ovf_d;
        end
    end

    assign bus.rd_data    = empty ? 10'd0 : mem[rptr];
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = cnt;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench for ps2_rx_fifo.
// Drives PS/2 frames, models the FIFO contents and error pulse counts.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 16;
    localparam int FL    = 8;
    localparam int TO    = 600;
    localparam int HALF  = 24;

    logic clk      = 1'b0;
    logic areset_n = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .DEPTH      (DEPTH),
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK100MHZ(clk),
        .areset_n (areset_n),
        .PS2_CLK  (ps2_clk),
        .PS2_DATA (ps2_data),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;
    int exp_perr = 0;
    int exp_ferr = 0;
    int exp_ovf  = 0;
    logic [9:0] exp_q[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;

    // Count pulse cycles so a stretched pulse also shows up.
    always @(negedge clk) begin
        if (bus.parity_err) n_perr++;
        if (bus.frame_err)  n_ferr++;
        if (bus.overflow)   n_ovf++;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_errs(string tag);
        check({tag, "_perr"}, n_perr, exp_perr);
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_ovf"},  n_ovf,  exp_ovf);
    endtask

    // One PS/2 bit: data set at the start of the high phase, then fall.
    task automatic send_bit(bit b, bit glitch, bit pop_stop);
        ps2_data = b;
        tick(4);
        if (glitch) begin
            ps2_clk = 1'b0;
            tick(FL - 1);
            ps2_clk = 1'b1;
            tick(HALF - 4 - (FL - 1));
        end else begin
            tick(HALF - 4);
        end
        ps2_clk = 1'b0;
        if (pop_stop) begin
            // Strobe cycle follows edge FL+2; the write lands on edge FL+3.
            tick(FL + 2);
            if (exp_q.size() > 0) begin
                check("pop_head", bus.rd_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            bus.rd_en = 1'b1;
            tick(1);
            bus.rd_en = 1'b0;
            tick(HALF - FL - 3);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop,
                              bit glitch, bit pop_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], glitch, 1'b0);
        send_bit(par, glitch, 1'b0);
        send_bit(~bad_stop, glitch, pop_stop);
        ps2_data = 1'b1;
        tick(8);
    endtask

    function automatic void model_push(logic [7:0] b);
        logic [9:0] v;
`ifdef PS2_SCANCODE_TAG_EN
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
        v = {m_ext, m_brk, b};
        m_ext = 1'b0;
        m_brk = 1'b0;
`else
        v = {2'b00, b};
`endif
        if (exp_q.size() == DEPTH)
            exp_ovf++;
        else
            exp_q.push_back(v);
    endfunction

    function automatic void model_err(bit parity);
        if (parity) exp_perr++;
        else        exp_ferr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    task automatic good(logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
        model_push(b);
    endtask

    task automatic read_one();
        int w;
        w = 0;
        while (bus.empty && w < 200) begin
            tick(1);
            w++;
        end
        if (w >= 200) begin
            check("rd_wait_timeout", 32'd1, 32'd0);
        end else begin
            check("rd_data", bus.rd_data, exp_q.pop_front());
            bus.rd_en = 1'b1;
            tick(1);
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic drain(string tag);
        while (exp_q.size() > 0)
            read_one();
        tick(1);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_count"}, bus.count, 0);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_full"},  bus.full, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_rdata"}, bus.rd_data, 0);
        check({tag, "_perr"},  bus.parity_err, 0);
        check({tag, "_ferr"},  bus.frame_err, 0);
        check({tag, "_ovf"},   bus.overflow, 0);
    endtask

    initial begin
        bus.rd_en = 1'b0;
        tick(3);
        check_reset("rst");
        areset_n = 1'b1;
        tick(5);

        // Basic frame
        good(8'h1C);
        check("t1_count", bus.count, 1);
        check("t1_empty", bus.empty, 0);
        drain("t1");

        // Parity error then a good frame
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        model_err(1'b1);
        check_errs("t2");
        check("t2_empty", bus.empty, 1);
        good(8'h32);
        drain("t2");

        // Timeout mid-frame
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(1'(i & 1), 1'b0, 1'b0);
        ps2_data = 1'b1;
        tick(TO + 50);
        model_err(1'b0);
        check_errs("t3");
        good(8'h45);
        drain("t3");

        // Bad stop, and bad stop with bad parity (frame_err only)
        send_frame(8'h21, 1'b0, 1'b1, 1'b0, 1'b0);
        model_err(1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        model_err(1'b0);
        check_errs("t3b");
        check("t3b_empty", bus.empty, 1);

        // Fill, overflow, push with simultaneous pop when full
        for (int i = 0; i < DEPTH; i++)
            good(8'(8'h10 + i));
        check("t4_full", bus.full, 1);
        check("t4_count", bus.count, DEPTH);
        good(8'h40);
        check_errs("t4_ovf");
        check("t4_head", bus.rd_data, exp_q[0]);
        send_frame(8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
        model_push(8'h41);
        check("t4_count2", bus.count, DEPTH);
        check("t4_full2", bus.full, 1);
        check_errs("t4_pop");
        drain("t4");

        // Prefix sequence
        good(8'hE0);
        good(8'hF0);
        good(8'h74);
        check("t5_count", bus.count, exp_q.size());
        drain("t5");

        // Glitches while idle (data low looks like a start bit)
        ps2_data = 1'b0;
        tick(4);
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(20);
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(20);
        check("t6_idle_empty", bus.empty, 1);
        // Glitches inside every bit of a frame
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        model_push(8'h5A);
        check_errs("t6");
        drain("t6");

        // Reset mid-frame with an entry already queued
        good(8'h11);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            send_bit(1'b1, 1'b0, 1'b0);
        areset_n = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick(2);
        check_reset("t7");
        ps2_data = 1'b1;
        areset_n = 1'b1;
        tick(5);
        good(8'h66);
        drain("t7");
        check_errs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
